// File: rtl/seq_memory_pkg.sv
// Shared types and constants for the sequence word store.
package seq_memory_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  // count must hold MEMORY_QTY itself, which can equal 2^ADDRESS_SIZE
  function automatic int count_width(input int address_size);
    return address_size + 1;
  endfunction

endpackage

// File: rtl/seq_memory_ram.sv
// Single-write, single-read word RAM with registered read and no reset so
// that it maps onto iCE40 EBR. Same-address read/write returns the old word.
module seq_memory_ram
  import seq_memory_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int MEMORY_QTY = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [WORD_SIZE-1:0]  wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [WORD_SIZE-1:0]  rdata
);

  logic [WORD_SIZE-1:0] mem_q [MEMORY_QTY];
  logic [WORD_SIZE-1:0] rdata_q;

  // write port and registered read port share the system clock
  always_ff @(posedge clock) begin
    if (we == ON) begin
      mem_q[waddr] <= wdata;
    end
    if (re == ON) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/seq_memory.sv
// Sequence word store: handshaked writes with a programmable busy window,
// per-address valid tracking, distinct-address count and a registered read.
// Define SEQ_MEMORY_BYPASS_EN to forward a same-edge write to a read of the
// same address; otherwise that read sees the old RAM word and valid bit.
module seq_memory
  import seq_memory_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int MEMORY_QTY   = 16,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    w_en,
  input  logic [ADDRESS_SIZE-1:0] w_addr,
  input  logic [WORD_SIZE-1:0]    w_data,
  output logic                    w_ready,
  input  logic                    r_en,
  input  logic [ADDRESS_SIZE-1:0] r_addr,
  output logic [WORD_SIZE-1:0]    r_data,
  output logic                    r_valid,
  output logic                    r_hit,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    full,
  output logic                    w_err
);

  localparam int CW  = count_width(ADDRESS_SIZE);
  localparam int RAW = (MEMORY_QTY > 1) ? $clog2(MEMORY_QTY) : 1;
  localparam int BW  = $clog2(WRITE_CYCLES + 2);

  localparam logic [CW-1:0] QTY      = CW'(MEMORY_QTY);
  localparam logic [BW-1:0] BUSY_LD  = BW'(WRITE_CYCLES);
  localparam logic [BW-1:0] BUSY_ONE = BW'(1);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_BUSY = BUSY;

  logic [0:0]            state_q, state_d;
  logic [BW-1:0]         busy_cnt_q, busy_cnt_d;
  logic [MEMORY_QTY-1:0] valid_q, valid_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  w_err_q, w_err_d;
  logic                  r_valid_q, r_valid_d;
  logic                  r_hit_q, r_hit_d;
  logic                  r_zero_q, r_zero_d;

  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_commit;
  logic                  r_in_range;
  logic                  byp_now;
  logic [RAW-1:0]        w_idx;
  logic [RAW-1:0]        r_idx;
  logic [WORD_SIZE-1:0]  ram_rdata;

  assign w_in_range = ({1'b0, w_addr} < QTY);
  assign r_in_range = ({1'b0, r_addr} < QTY);
  assign w_idx      = w_addr[RAW-1:0];
  assign r_idx      = r_addr[RAW-1:0];
  assign w_ready    = (state_q == ST_IDLE);
  assign w_accept   = w_en && w_ready;
  assign w_commit   = w_accept && w_in_range;

  seq_memory_ram #(
    .WORD_SIZE  (WORD_SIZE),
    .MEMORY_QTY (MEMORY_QTY),
    .ADDR_W     (RAW)
  ) u_ram (
    .clock (clock),
    .we    (w_commit),
    .waddr (w_idx),
    .wdata (w_data),
    .re    (r_en),
    .raddr (r_idx),
    .rdata (ram_rdata)
  );

  // write-busy FSM: the counter holds the remaining busy cycles
  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept && (WRITE_CYCLES > 0)) begin
          state_d    = ST_BUSY;
          busy_cnt_d = BUSY_LD;
        end
      end
      ST_BUSY: begin
        if (busy_cnt_q == BUSY_ONE) begin
          state_d    = ST_IDLE;
          busy_cnt_d = '0;
        end else begin
          busy_cnt_d = busy_cnt_q - BUSY_ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        busy_cnt_d = '0;
      end
    endcase
  end

  // valid bitmap, distinct-address count and out-of-range write flag
  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    w_err_d = OFF;
    if (w_commit) begin
      valid_d[w_idx] = ON;
      if (!valid_q[w_idx]) begin
        count_d = count_q + CW'(1);
      end
    end
    if (w_accept && !w_in_range) begin
      w_err_d = ON;
    end
  end

  // read side flags; r_zero forces r_data to 0 after reset or out-of-range
  always_comb begin
    r_valid_d = r_en;
    r_hit_d   = r_hit_q;
    r_zero_d  = r_zero_q;
    if (r_en) begin
      r_zero_d = !r_in_range;
      r_hit_d  = (r_in_range && valid_q[r_idx]) || byp_now;
    end
  end

  // control and bookkeeping registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_cnt_q <= '0;
      valid_q    <= '0;
      count_q    <= '0;
      w_err_q    <= OFF;
      r_valid_q  <= OFF;
      r_hit_q    <= OFF;
      r_zero_q   <= ON;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      w_err_q    <= w_err_d;
      r_valid_q  <= r_valid_d;
      r_hit_q    <= r_hit_d;
      r_zero_q   <= r_zero_d;
    end
  end

`ifdef SEQ_MEMORY_BYPASS_EN
  logic                 byp_q, byp_d;
  logic [WORD_SIZE-1:0] byp_data_q, byp_data_d;

  assign byp_now = r_en && w_commit && (r_addr == w_addr);

  // capture the forwarded word alongside the read it belongs to
  always_comb begin
    byp_d      = byp_q;
    byp_data_d = byp_data_q;
    if (r_en) begin
      byp_d = byp_now;
      if (byp_now) begin
        byp_data_d = w_data;
      end
    end
  end

  // forwarding registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byp_q      <= OFF;
      byp_data_q <= '0;
    end else begin
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign r_data = r_zero_q ? '0 : (byp_q ? byp_data_q : ram_rdata);
`else
  assign byp_now = OFF;
  assign r_data  = r_zero_q ? '0 : ram_rdata;
`endif

  assign r_valid = r_valid_q;
  assign r_hit   = r_hit_q;
  assign count   = count_q;
  assign full    = (count_q == QTY);
  assign w_err   = w_err_q;

endmodule

// File: tb/tb_seq_memory.sv
// Directed bench for seq_memory with a read scoreboard.
module tb_seq_memory;

  localparam int WS = 8;
  localparam int AS = 5;
  localparam int MQ = 16;
  localparam int WC = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          w_en = 1'b0;
  logic [AS-1:0] w_addr = '0;
  logic [WS-1:0] w_data = '0;
  logic          w_ready;
  logic          r_en = 1'b0;
  logic [AS-1:0] r_addr = '0;
  logic [WS-1:0] r_data;
  logic          r_valid;
  logic          r_hit;
  logic [AS:0]   count;
  logic          full;
  logic          w_err;

  typedef struct {
    logic [WS-1:0] data;
    logic          hit;
    logic          chk_data;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int waited;

`ifdef SEQ_MEMORY_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  seq_memory #(
    .WORD_SIZE(WS), .ADDRESS_SIZE(AS), .MEMORY_QTY(MQ), .WRITE_CYCLES(WC)
  ) dut (
    .clock(clock), .reset(reset),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid),
    .r_hit(r_hit), .count(count), .full(full), .w_err(w_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!w_ready && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) check("wait_idle_timeout", 32'(w_ready), 32'd1);
  endtask

  task automatic do_write(input logic [AS-1:0] a, input logic [WS-1:0] d, output int nwait);
    w_en   = 1'b1;
    w_addr = a;
    w_data = d;
    nwait  = 0;
    while (!w_ready && nwait < 10) begin
      tick();
      nwait++;
    end
    if (nwait >= 10) check("write_accept_timeout", 32'(w_ready), 32'd1);
    else tick();
    w_en = 1'b0;
  endtask

  task automatic rd_issue(input logic [AS-1:0] a, input logic [WS-1:0] d, input logic hit, input logic chk);
    rd_exp_t e;
    e.data = d;
    e.hit = hit;
    e.chk_data = chk;
    r_en   = 1'b1;
    r_addr = a;
    sb_q.push_back(e);
  endtask

  task automatic rd_collect(input string tag);
    rd_exp_t e;
    check({tag, "_r_valid"}, 32'(r_valid), 32'd1);
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_r_hit"}, 32'(r_hit), 32'(e.hit));
      if (e.chk_data) check({tag, "_r_data"}, 32'(r_data), 32'(e.data));
    end
  endtask

  task automatic rd_single(input string tag, input logic [AS-1:0] a, input logic [WS-1:0] d,
                           input logic hit, input logic chk);
    rd_issue(a, d, hit, chk);
    tick();
    r_en = 1'b0;
    rd_collect(tag);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_w_ready", 32'(w_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_r_valid", 32'(r_valid), 32'd0);
    check("rst_r_hit", 32'(r_hit), 32'd0);
    check("rst_r_data", 32'(r_data), 32'd0);
    check("rst_w_err", 32'(w_err), 32'd0);

    // first write, then a held write that must wait out the busy window
    do_write(5'd3, 8'hA5, waited);
    check("a5_wait", 32'(waited), 32'd0);
    check("a5_w_ready_low", 32'(w_ready), 32'd0);
    check("a5_count", 32'(count), 32'd1);
    do_write(5'd4, 8'h3C, waited);
    check("busy_len", 32'(waited), 32'(WC));
    check("3c_count", 32'(count), 32'd2);

    // back-to-back reads
    rd_issue(5'd3, 8'hA5, 1'b1, 1'b1);
    tick();
    rd_collect("rd3");
    rd_issue(5'd4, 8'h3C, 1'b1, 1'b1);
    tick();
    r_en = 1'b0;
    rd_collect("rd4");
    tick();
    check("r_valid_one_cycle", 32'(r_valid), 32'd0);

    // fill every address
    for (int i = 0; i < MQ - 1; i++) begin
      do_write(AS'(i), 8'(8'h40 + i), waited);
    end
    check("fill15_count", 32'(count), 32'd15);
    check("fill15_full", 32'(full), 32'd0);
    do_write(AS'(MQ - 1), 8'h4F, waited);
    check("fill16_count", 32'(count), 32'd16);
    check("fill16_full", 32'(full), 32'd1);
    do_write(5'd0, 8'h11, waited);
    check("rewrite_count", 32'(count), 32'd16);
    wait_idle();
    rd_single("rd0", 5'd0, 8'h11, 1'b1, 1'b1);
    rd_single("rd9", 5'd9, 8'h49, 1'b1, 1'b1);

    // out-of-range write
    wait_idle();
    do_write(5'd20, 8'hEE, waited);
    check("oor_w_err", 32'(w_err), 32'd1);
    check("oor_count", 32'(count), 32'd16);
    tick();
    check("oor_w_err_pulse", 32'(w_err), 32'd0);
    rd_single("rd20", 5'd20, 8'h00, 1'b0, 1'b1);

    // same-edge write and read of one address
    wait_idle();
    do_write(5'd5, 8'h22, waited);
    wait_idle();
    w_en = 1'b1;
    w_addr = 5'd5;
    w_data = 8'h77;
    rd_issue(5'd5, BYP ? 8'h77 : 8'h22, 1'b1, 1'b1);
    tick();
    w_en = 1'b0;
    r_en = 1'b0;
    rd_collect("same5");
    wait_idle();
    rd_single("rd5_after", 5'd5, 8'h77, 1'b1, 1'b1);

    // reset in the middle of the busy window
    wait_idle();
    do_write(5'd7, 8'h99, waited);
    check("pre_rst_busy", 32'(w_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_w_ready", 32'(w_ready), 32'd1);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_full", 32'(full), 32'd0);
    check("midrst_r_data", 32'(r_data), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    rd_single("rd7_after_rst", 5'd7, 8'h00, 1'b0, 1'b0);

    // same-edge write and read of an address not yet valid
    w_en = 1'b1;
    w_addr = 5'd8;
    w_data = 8'h5A;
    rd_issue(5'd8, 8'h5A, BYP, BYP);
    tick();
    w_en = 1'b0;
    r_en = 1'b0;
    rd_collect("same8");
    check("rst_then_count", 32'(count), 32'd1);
    wait_idle();
    rd_single("rd8_after", 5'd8, 8'h5A, 1'b1, 1'b1);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
